img_rom_arbiter: RTL and testbench
==================================

// Module: img_rom_arbiter
// PURPOSE
//  Shares one single-port, read-only image ROM (fixed read latency ROM_LAT) between two clients.
//  The VGA display path has absolute priority inside the image window.
//  An auxiliary client (note/sprite loader) uses a valid/ready handshake and owns the ROM outside the window.
//  Sits between the scan counters, the image ROM IP and the colour mux.
// PARAMETERS
//  ADDR_W    19   ROM address width
//  DATA_W    12   ROM word width, packed {R[11:8],G[7:4],B[3:0]}
//  H_OFFSET  480  first window column (h_count)
//  V_OFFSET  100  first window row (v_count)
//  IMG_W     160  window/image width in pixels
//  IMG_H     380  window/image height in pixels
//  ROM_LAT   1    ROM clock-to-data latency in cycles (1..3)
// PORTS
//  clk            in   1       pixel clock; one h_count step per cycle
//  rst_n          in   1       asynchronous, active-low reset
//  h_count        in   10      horizontal scan position
//  v_count        in   9       vertical scan position
//  disp_color     out  12      {B,G,R} pixel, 0 outside window
//  disp_active    out  1       pixel is inside window (aligned with disp_color)
//  aux_req_valid  in   1       aux read request
//  aux_req_addr   in   ADDR_W  aux read address
//  aux_req_ready  out  1       request accepted this cycle when valid&ready
//  aux_rsp_valid  out  1       one-cycle response pulse, no backpressure
//  aux_rsp_data   out  DATA_W  response data ({R,G,B}, unswapped)
//  aux_rsp_err    out  1       with rsp_valid: address >= IMG_W*IMG_H, data forced 0
//  rom_addr       out  ADDR_W  to ROM addra
//  rom_data       in   DATA_W  from ROM douta
// BEHAVIOUR
//  Reset: all outputs 0, aux_req_ready=0, owner pipeline flushed; in-flight aux reads are dropped, no rsp.
//  win = h in [H_OFFSET,H_OFFSET+IMG_W) && v in [V_OFFSET,V_OFFSET+IMG_H), evaluated on current inputs.
//  Owner FSM, one decision per cycle:
//    DISP (win=1): rom_addr=(v-V_OFFSET)*IMG_W+(h-H_OFFSET), computed in ADDR_W bits; aux_req_ready=0.
//    AUX  (win=0 & aux_req_valid): aux_req_ready=1; in-range addr drives rom_addr, out-of-range does not touch ROM.
//    IDLE (win=0 & !valid): rom_addr holds its last value.
//  aux_req_ready is combinational from win; aux must hold valid/addr stable until accepted.
//  Owner tag {DISP,AUX,AUX_ERR,NONE} shifts through ROM_LAT+1 stages; output register at the last stage.
//  Display latency: disp_color/disp_active lag h_count by exactly ROM_LAT+1 cycles; top level delays syncs to match.
//  disp_color = {rom[3:0],rom[7:4],rom[11:8]} when tag=DISP, else 0.
//  aux_rsp_valid=1 exactly ROM_LAT+1 cycles after acceptance; aux_rsp_err rides the same pipeline.
//  Back-to-back aux acceptance allowed, one per cycle; responses return in order.
//  Window edge: the last blank cycle before win may accept aux; the pipeline keeps the two owners separate.
//  The first DISP cycle after it loses nothing.
//  Wrap-around: h/v counter wrap needs no special case; win simply deasserts.
//  aux_rsp_data holds its last value when aux_rsp_valid=0.
// CONFIGURATION
//  IMG_ARB_STATS_EN defined: adds port aux_stall_cnt out 16.
//    Counts cycles with aux_req_valid & !aux_req_ready; saturates at 16'hFFFF.
//    Clears on reset and when v_count==0 && h_count==0.
//  IMG_ARB_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  img_pkg: IMG_W, IMG_H, H_OFFSET, V_OFFSET, rgb12_t, owner_t enum, function rgb_to_bgr().
//  Sub-module img_owner_pipe: parameterised ROM_LAT+1 delay line for owner_t plus aux error flag.
//  The ROM instance stays outside this block.
// TESTING
//  Reset mid-frame with 2 aux reads in flight -> no aux_rsp_valid after release; all outputs 0 during reset.
//  h=480,v=100 -> rom_addr=0; h=639,v=479 -> rom_addr=60799.
//    ROM word 12'hABC -> disp_color=12'hCBA, disp_active=1, at ROM_LAT+1 cycles.
//  Aux valid addr=5 held at h=490,v=150 -> ready=0 until h=640 (win=0).
//    Accepted there; rsp_valid with ROM data 2 cycles later (ROM_LAT=1).
//  Aux burst addrs 10,11,12 in blanking -> three consecutive rsp pulses, in order, correct data.
//  Aux addr 60800 -> rsp_valid=1, rsp_err=1, data=0; rom_addr unchanged that cycle.
//  STATS_EN: aux held valid across 160 window cycles -> aux_stall_cnt=160; clears at h=0,v=0.

Source files
------------

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared constants, types and helpers for the image ROM
//                arbiter: window geometry, 12-bit colour word, owner tag
//                and the RGB->BGR channel swap used on the display path.
//  Revision    : 1.0  initial release
// ============================================================================
package img_pkg;

    localparam int unsigned IMG_W    = 160;
    localparam int unsigned IMG_H    = 380;
    localparam int unsigned H_OFFSET = 480;
    localparam int unsigned V_OFFSET = 100;

    // Packed {R[11:8], G[7:4], B[3:0]} as stored in the ROM
    typedef logic [11:0] rgb12_t;

    // Who issued the ROM read that is travelling down the pipeline
    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_DISP    = 2'd1,
        OWN_AUX     = 2'd2,
        OWN_AUX_ERR = 2'd3
    } owner_t;

    // The colour mux downstream expects {B,G,R}
    function automatic rgb12_t rgb_to_bgr(input rgb12_t c);
        return {c[3:0], c[7:4], c[11:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/img_owner_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : img_owner_pipe
//  Description : LAT+1 stage delay line for the owner tag. The tag for the
//                read issued in cycle t appears on tag_tap in cycle t+LAT
//                (same cycle the ROM returns its data) and on tag_out in
//                cycle t+LAT+1 (aligned with the registered outputs).
//                The aux error flag rides along as the OWN_AUX_ERR tag.
//  Ports       : clk, rst_n     clock, async active-low reset (flushes)
//                tag_in         owner decided this cycle
//                tag_tap        owner delayed LAT cycles
//                tag_out        owner delayed LAT+1 cycles
//                err_out        tag_out is an out-of-range aux read
//  Revision    : 1.0  initial release
// ============================================================================
module img_owner_pipe
    import img_pkg::*;
#(
    parameter int unsigned LAT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  owner_t tag_in,
    output owner_t tag_tap,
    output owner_t tag_out,
    output logic   err_out
);

    owner_t stage_q [LAT+1];
    owner_t stage_d [LAT+1];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i <= int'(LAT); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= int'(LAT); i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_tap = stage_q[LAT-1];
    assign tag_out = stage_q[LAT];
    assign err_out = (stage_q[LAT] == OWN_AUX_ERR);

endmodule
`default_nettype wire

// File: rtl/img_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : img_rom_arbiter
//  Description : Shares one single-port image ROM between the VGA display
//                path (absolute priority inside the image window) and an
//                auxiliary valid/ready reader (owns the ROM outside it).
//                Display and aux results both appear ROM_LAT+1 cycles after
//                the cycle that issued the read.
//  Ports       : clk, rst_n                 pixel clock, async active-low reset
//                h_count, v_count           scan position
//                disp_color, disp_active    {B,G,R} pixel and window flag
//                aux_req_valid/addr/ready   aux request handshake
//                aux_rsp_valid/data/err     aux response pulse
//                rom_addr, rom_data         ROM address / read data
//                aux_stall_cnt              (IMG_ARB_STATS_EN only) stall count
//  Config      : `define IMG_ARB_STATS_EN to add the aux stall counter port.
//  Revision    : 1.0  initial release
// ============================================================================
module img_rom_arbiter #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 12,
    parameter int unsigned H_OFFSET = img_pkg::H_OFFSET,
    parameter int unsigned V_OFFSET = img_pkg::V_OFFSET,
    parameter int unsigned IMG_W    = img_pkg::IMG_W,
    parameter int unsigned IMG_H    = img_pkg::IMG_H,
    parameter int unsigned ROM_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        h_count,
    input  logic [8:0]        v_count,
    output logic [11:0]       disp_color,
    output logic              disp_active,
    input  logic              aux_req_valid,
    input  logic [ADDR_W-1:0] aux_req_addr,
    output logic              aux_req_ready,
    output logic              aux_rsp_valid,
    output logic [DATA_W-1:0] aux_rsp_data,
    output logic              aux_rsp_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef IMG_ARB_STATS_EN
    ,
    output logic [15:0]       aux_stall_cnt
`endif
);
    import img_pkg::*;

    // ------------------------------------------------------------------
    // Window decode and display address, from the current scan position
    // ------------------------------------------------------------------
    logic              h_in, v_in, win;
    logic [ADDR_W-1:0] v_rel, h_rel, disp_addr;
    logic              aux_oor;

    assign h_in = (32'(h_count) >= H_OFFSET) && (32'(h_count) < H_OFFSET + IMG_W);
    assign v_in = (32'(v_count) >= V_OFFSET) && (32'(v_count) < V_OFFSET + IMG_H);
    assign win  = h_in && v_in;

    assign v_rel     = ADDR_W'(32'(v_count) - V_OFFSET);
    assign h_rel     = ADDR_W'(32'(h_count) - H_OFFSET);
    assign disp_addr = v_rel * ADDR_W'(IMG_W) + h_rel;

    assign aux_oor = (32'(aux_req_addr) >= IMG_W * IMG_H);

    // ------------------------------------------------------------------
    // Owner decision, one per cycle. rom_addr is combinational so the ROM
    // samples it on the next edge; idle and error cycles hold the last
    // address. The whole decision is masked while reset is asserted so
    // ready and rom_addr read 0 during reset.
    // ------------------------------------------------------------------
    owner_t            owner_d;
    logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
    logic              ready_d;

    always_comb begin
        owner_d    = OWN_NONE;
        rom_addr_d = rom_addr_q;
        ready_d    = 1'b0;
        if (rst_n) begin
            if (win) begin
                owner_d    = OWN_DISP;
                rom_addr_d = disp_addr;
            end else begin
                ready_d = 1'b1;
                if (aux_req_valid) begin
                    if (aux_oor) begin
                        owner_d = OWN_AUX_ERR;
                    end else begin
                        owner_d    = OWN_AUX;
                        rom_addr_d = aux_req_addr;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
        end
    end

    assign rom_addr      = rom_addr_d;
    assign aux_req_ready = ready_d;

    // ------------------------------------------------------------------
    // Owner tag pipeline
    // ------------------------------------------------------------------
    owner_t tag_tap, tag_out;
    logic   err_out;

    img_owner_pipe #(
        .LAT (ROM_LAT)
    ) u_owner_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (owner_d),
        .tag_tap (tag_tap),
        .tag_out (tag_out),
        .err_out (err_out)
    );

    // ------------------------------------------------------------------
    // Output register: captures ROM data in the cycle it is valid, steered
    // by the tag that travelled alongside the read.
    // ------------------------------------------------------------------
    logic [11:0]       disp_color_d, disp_color_q;
    logic [DATA_W-1:0] aux_rsp_data_d, aux_rsp_data_q;

    always_comb begin
        disp_color_d   = '0;
        aux_rsp_data_d = aux_rsp_data_q;
        case (tag_tap)
            OWN_DISP:    disp_color_d   = rgb_to_bgr(rgb12_t'(rom_data));
            OWN_AUX:     aux_rsp_data_d = rom_data;
            OWN_AUX_ERR: aux_rsp_data_d = '0;
            default:     ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_color_q   <= '0;
            aux_rsp_data_q <= '0;
        end else begin
            disp_color_q   <= disp_color_d;
            aux_rsp_data_q <= aux_rsp_data_d;
        end
    end

    assign disp_color    = disp_color_q;
    assign disp_active   = (tag_out == OWN_DISP);
    assign aux_rsp_valid = (tag_out == OWN_AUX) || (tag_out == OWN_AUX_ERR);
    assign aux_rsp_err   = err_out;
    assign aux_rsp_data  = aux_rsp_data_q;

`ifdef IMG_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Aux stall counter: saturating, cleared at the top-left of each frame
    // ------------------------------------------------------------------
    logic [15:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((v_count == 9'd0) && (h_count == 10'd0)) begin
            stall_cnt_d = '0;
        end else if (aux_req_valid && !aux_req_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign aux_stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_img_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_rom_arbiter
//  Description : Directed self-checking bench for img_rom_arbiter with a
//                one-cycle-latency behavioural ROM. ROM word at address 0 is
//                12'hABC, every other address a holds (a*13+1) mod 4096.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_img_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  h_count = '0;
    logic [8:0]  v_count = '0;
    logic [11:0] disp_color;
    logic        disp_active;
    logic        aux_req_valid = 1'b0;
    logic [18:0] aux_req_addr = '0;
    logic        aux_req_ready;
    logic        aux_rsp_valid;
    logic [11:0] aux_rsp_data;
    logic        aux_rsp_err;
    logic [18:0] rom_addr;
    logic [11:0] rom_data = '0;
`ifdef IMG_ARB_STATS_EN
    logic [15:0] aux_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    img_rom_arbiter #(
        .ADDR_W  (19),
        .DATA_W  (12),
        .ROM_LAT (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .h_count       (h_count),
        .v_count       (v_count),
        .disp_color    (disp_color),
        .disp_active   (disp_active),
        .aux_req_valid (aux_req_valid),
        .aux_req_addr  (aux_req_addr),
        .aux_req_ready (aux_req_ready),
        .aux_rsp_valid (aux_rsp_valid),
        .aux_rsp_data  (aux_rsp_data),
        .aux_rsp_err   (aux_rsp_err),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data)
`ifdef IMG_ARB_STATS_EN
        ,
        .aux_stall_cnt (aux_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_word(input logic [18:0] a);
        if (a == 19'd0) return 12'hABC;
        return 12'(32'(a) * 13 + 1);
    endfunction

    // One-cycle ROM
    always @(posedge clk) rom_data <= rom_word(rom_addr);

    // Drive one cycle of inputs just after the edge, return at the negedge
    task automatic cyc(input int h, input int v, input logic val, input int addr);
        @(posedge clk);
        #1;
        h_count       = 10'(h);
        v_count       = 9'(v);
        aux_req_valid = val;
        aux_req_addr  = 19'(addr);
        @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (disp_color !== 12'h000) begin bad++; $display("FAIL rst_color got=%h want=000", disp_color); end
        total++; if (disp_active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", disp_active); end
        total++; if (aux_req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", aux_req_ready); end
        total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", aux_rsp_valid); end
        total++; if (aux_rsp_data !== 12'h000) begin bad++; $display("FAIL rst_rsp_data got=%h want=000", aux_rsp_data); end
        total++; if (aux_rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err got=%b want=0", aux_rsp_err); end
        total++; if (rom_addr !== 19'd0) begin bad++; $display("FAIL rst_rom_addr got=%0d want=0", rom_addr); end
`ifdef IMG_ARB_STATS_EN
        total++; if (aux_stall_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall got=%0d want=0", aux_stall_cnt); end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_inflight;
        cyc(700, 50, 1'b1, 3);
        total++; if (aux_req_ready !== 1'b1) begin bad++; $display("FAIL inflight_ready0 got=%b want=1", aux_req_ready); end
        cyc(701, 50, 1'b1, 4);
        total++; if (rom_addr !== 19'd4) begin bad++; $display("FAIL inflight_addr got=%0d want=4", rom_addr); end
        rst_n = 1'b0;
        #1;
        total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL inrst_rsp_valid got=%b want=0", aux_rsp_valid); end
        total++; if (aux_req_ready !== 1'b0) begin bad++; $display("FAIL inrst_ready got=%b want=0", aux_req_ready); end
        total++; if (rom_addr !== 19'd0) begin bad++; $display("FAIL inrst_rom_addr got=%0d want=0", rom_addr); end
        total++; if (aux_rsp_data !== 12'h000) begin bad++; $display("FAIL inrst_rsp_data got=%h want=000", aux_rsp_data); end
        cyc(702, 50, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL inrst_rsp_valid2 got=%b want=0", aux_rsp_valid); end
        cyc(703, 50, 1'b0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(704 + i, 50, 1'b0, 0);
            total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL postrst_rsp_valid cyc=%0d got=%b want=0", i, aux_rsp_valid); end
        end
    endtask

    task automatic test_disp;
        cyc(479, 100, 1'b0, 0);
        cyc(480, 100, 1'b0, 0);
        total++; if (rom_addr !== 19'd0) begin bad++; $display("FAIL disp_addr_first got=%0d want=0", rom_addr); end
        total++; if (aux_req_ready !== 1'b0) begin bad++; $display("FAIL disp_ready got=%b want=0", aux_req_ready); end
        cyc(481, 100, 1'b0, 0);
        total++; if (disp_active !== 1'b0) begin bad++; $display("FAIL disp_lat_early got=%b want=0", disp_active); end
        cyc(482, 100, 1'b0, 0);
        total++; if (disp_active !== 1'b1) begin bad++; $display("FAIL disp_active got=%b want=1", disp_active); end
        total++; if (disp_color !== 12'hCBA) begin bad++; $display("FAIL disp_swap got=%h want=cba", disp_color); end
        cyc(638, 479, 1'b0, 0);
        cyc(639, 479, 1'b0, 0);
        total++; if (rom_addr !== 19'd60799) begin bad++; $display("FAIL disp_addr_last got=%0d want=60799", rom_addr); end
        cyc(640, 479, 1'b0, 0);
        cyc(641, 479, 1'b0, 0);
        total++; if (disp_color !== 12'h47F) begin bad++; $display("FAIL disp_last_color got=%h want=47f", disp_color); end
        total++; if (disp_active !== 1'b1) begin bad++; $display("FAIL disp_last_active got=%b want=1", disp_active); end
        cyc(642, 479, 1'b0, 0);
        total++; if (disp_active !== 1'b0) begin bad++; $display("FAIL disp_exit_active got=%b want=0", disp_active); end
        total++; if (disp_color !== 12'h000) begin bad++; $display("FAIL disp_exit_color got=%h want=000", disp_color); end
    endtask

    task automatic test_aux_stall;
        cyc(0, 0, 1'b0, 0);
        for (int h = 480; h < 640; h++) begin
            cyc(h, 150, 1'b1, 5);
            total++; if (aux_req_ready !== 1'b0) begin bad++; $display("FAIL stall_ready h=%0d got=%b want=0", h, aux_req_ready); end
        end
        cyc(640, 150, 1'b1, 5);
        total++; if (aux_req_ready !== 1'b1) begin bad++; $display("FAIL stall_accept got=%b want=1", aux_req_ready); end
        total++; if (rom_addr !== 19'd5) begin bad++; $display("FAIL stall_rom_addr got=%0d want=5", rom_addr); end
`ifdef IMG_ARB_STATS_EN
        total++; if (aux_stall_cnt !== 16'd160) begin bad++; $display("FAIL stall_cnt got=%0d want=160", aux_stall_cnt); end
`endif
        cyc(641, 150, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_rsp_early got=%b want=0", aux_rsp_valid); end
`ifdef IMG_ARB_STATS_EN
        total++; if (aux_stall_cnt !== 16'd160) begin bad++; $display("FAIL stall_cnt_hold got=%0d want=160", aux_stall_cnt); end
`endif
        cyc(642, 150, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_rsp_valid got=%b want=1", aux_rsp_valid); end
        total++; if (aux_rsp_data !== 12'h042) begin bad++; $display("FAIL stall_rsp_data got=%h want=042", aux_rsp_data); end
        total++; if (aux_rsp_err !== 1'b0) begin bad++; $display("FAIL stall_rsp_err got=%b want=0", aux_rsp_err); end
        cyc(643, 150, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0) begin bad++; $display("FAIL stall_rsp_pulse got=%b want=0", aux_rsp_valid); end
        total++; if (aux_rsp_data !== 12'h042) begin bad++; $display("FAIL stall_rsp_hold got=%h want=042", aux_rsp_data); end
`ifdef IMG_ARB_STATS_EN
        cyc(0, 0, 1'b0, 0);
        cyc(1, 0, 1'b0, 0);
        total++; if (aux_stall_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt_clear got=%0d want=0", aux_stall_cnt); end
`endif
    endtask

    task automatic test_burst;
        cyc(700, 200, 1'b1, 10);
        total++; if (aux_req_ready !== 1'b1 || rom_addr !== 19'd10) begin bad++; $display("FAIL burst_a0 got=%b/%0d want=1/10", aux_req_ready, rom_addr); end
        cyc(701, 200, 1'b1, 11);
        total++; if (rom_addr !== 19'd11) begin bad++; $display("FAIL burst_a1 got=%0d want=11", rom_addr); end
        cyc(702, 200, 1'b1, 12);
        total++; if (rom_addr !== 19'd12) begin bad++; $display("FAIL burst_a2 got=%0d want=12", rom_addr); end
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_data !== 12'h083) begin bad++; $display("FAIL burst_r0 got=%b/%h want=1/083", aux_rsp_valid, aux_rsp_data); end
        cyc(703, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_data !== 12'h090) begin bad++; $display("FAIL burst_r1 got=%b/%h want=1/090", aux_rsp_valid, aux_rsp_data); end
        cyc(704, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_data !== 12'h09D) begin bad++; $display("FAIL burst_r2 got=%b/%h want=1/09d", aux_rsp_valid, aux_rsp_data); end
        cyc(705, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0 || aux_rsp_data !== 12'h09D) begin bad++; $display("FAIL burst_end got=%b/%h want=0/09d", aux_rsp_valid, aux_rsp_data); end
        total++; if (rom_addr !== 19'd12) begin bad++; $display("FAIL burst_idle_hold got=%0d want=12", rom_addr); end
    endtask

    task automatic test_err;
        cyc(710, 200, 1'b1, 7);
        total++; if (rom_addr !== 19'd7) begin bad++; $display("FAIL err_pre_addr got=%0d want=7", rom_addr); end
        cyc(711, 200, 1'b1, 60800);
        total++; if (aux_req_ready !== 1'b1) begin bad++; $display("FAIL err_ready got=%b want=1", aux_req_ready); end
        total++; if (rom_addr !== 19'd7) begin bad++; $display("FAIL err_rom_untouched got=%0d want=7", rom_addr); end
        cyc(712, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_data !== 12'h05C || aux_rsp_err !== 1'b0) begin bad++; $display("FAIL err_prev_rsp got=%b/%h/%b want=1/05c/0", aux_rsp_valid, aux_rsp_data, aux_rsp_err); end
        cyc(713, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_err !== 1'b1 || aux_rsp_data !== 12'h000) begin bad++; $display("FAIL err_rsp got=%b/%b/%h want=1/1/000", aux_rsp_valid, aux_rsp_err, aux_rsp_data); end
        cyc(714, 200, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0 || aux_rsp_err !== 1'b0) begin bad++; $display("FAIL err_end got=%b/%b want=0/0", aux_rsp_valid, aux_rsp_err); end
    endtask

    task automatic test_back_to_back;
        cyc(479, 100, 1'b1, 20);
        total++; if (aux_req_ready !== 1'b1 || rom_addr !== 19'd20) begin bad++; $display("FAIL edge_accept got=%b/%0d want=1/20", aux_req_ready, rom_addr); end
        cyc(480, 100, 1'b0, 0);
        total++; if (aux_req_ready !== 1'b0 || rom_addr !== 19'd0) begin bad++; $display("FAIL edge_disp got=%b/%0d want=0/0", aux_req_ready, rom_addr); end
        cyc(481, 100, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b1 || aux_rsp_data !== 12'h105 || disp_active !== 1'b0) begin bad++; $display("FAIL edge_aux_rsp got=%b/%h/%b want=1/105/0", aux_rsp_valid, aux_rsp_data, disp_active); end
        cyc(482, 100, 1'b0, 0);
        total++; if (aux_rsp_valid !== 1'b0 || disp_active !== 1'b1 || disp_color !== 12'hCBA) begin bad++; $display("FAIL edge_disp_out got=%b/%b/%h want=0/1/cba", aux_rsp_valid, disp_active, disp_color); end
    endtask

    initial begin
        test_reset();
        test_reset_inflight();
        test_disp();
        test_aux_stall();
        test_burst();
        test_err();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
